// File: rtl/inst_fetch_mem.sv
//------------------------------------------------------------------------------
// Module   : inst_fetch_mem
// Brief    : Fetch-stage instruction memory: registered read with valid/ready,
//            flush, loader write port and post-reset NOP fill.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch_mem #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 140,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'hFFFF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_req_ready,
  input  logic              i_flush,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_inst,
  output logic [ADDR_W-1:0] o_resp_addr,
  output logic              o_resp_fault,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_init_done
);

  localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_init_ptr;
  logic [IDX_W-1:0]   w_init_ptr_nxt;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_idx;
  logic [DATA_W-1:0]  w_mem_data;

  logic               r_resp_valid;
  logic               r_resp_fault;
  logic [DATA_W-1:0]  r_resp_inst;
  logic [ADDR_W-1:0]  r_resp_addr;

  logic               w_run;
  logic               w_req_in_range;
  logic               w_load_in_range;
  logic               w_accept;
  logic [IDX_W-1:0]   w_req_idx;

  // Full-width unsigned compares: addresses never wrap into the array.
  assign w_run           = (r_state == ST_RUN);
  assign w_req_in_range  = ({1'b0, i_req_addr}  < c_depth);
  assign w_load_in_range = ({1'b0, i_load_addr} < c_depth);
  assign w_req_idx       = i_req_addr[IDX_W-1:0];
  assign o_req_ready     = w_run && !i_load_en && (!r_resp_valid || i_resp_ready);
  assign w_accept        = i_req_valid && o_req_ready && !i_flush;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_mem_we       = 1'b0;
    w_mem_idx      = r_init_ptr;
    w_mem_data     = NOP_WORD;
    case (r_state)
      ST_INIT: begin
        w_mem_we       = 1'b1;
        w_init_ptr_nxt = r_init_ptr + IDX_W'(1);
        if (r_init_ptr == c_last_idx) begin
          w_state_nxt    = ST_RUN;
          w_init_ptr_nxt = '0;
        end
      end
      ST_RUN: begin
        if (i_load_en && w_load_in_range) begin
          w_mem_we   = 1'b1;
          w_mem_idx  = i_load_addr[IDX_W-1:0];
          w_mem_data = i_load_data;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_data;
    end
  end

  // Flush outranks both a new accept and a held (stalled) response.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_inst  <= NOP_WORD;
      r_resp_addr  <= '0;
    end else if (w_run && i_flush) begin
      r_resp_valid <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_addr  <= i_req_addr;
      r_resp_fault <= !w_req_in_range;
      r_resp_inst  <= w_req_in_range ? r_mem[w_req_idx] : NOP_WORD;
    end else if (i_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_fault = r_resp_fault;
  assign o_resp_inst  = r_resp_inst;
  assign o_resp_addr  = r_resp_addr;
  assign o_init_done  = w_run;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_mem.sv
//------------------------------------------------------------------------------
// Module   : tb_inst_fetch_mem
// Brief    : Scoreboard bench for inst_fetch_mem against an array reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_mem;

  localparam int DEPTH = 140;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [15:0] i_req_addr = '0;
  logic        o_req_ready;
  logic        i_flush = 1'b0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b1;
  logic [15:0] o_resp_inst;
  logic [15:0] o_resp_addr;
  logic        o_resp_fault;
  logic        i_load_en = 1'b0;
  logic [15:0] i_load_addr = '0;
  logic [15:0] i_load_data = '0;
  logic        o_init_done;

  inst_fetch_mem #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .DEPTH   (DEPTH),
    .NOP_WORD(16'hFFFF)
  ) u_dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .o_req_ready (o_req_ready),
    .i_flush     (i_flush),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_resp_inst (o_resp_inst),
    .o_resp_addr (o_resp_addr),
    .o_resp_fault(o_resp_fault),
    .i_load_en   (i_load_en),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .o_init_done (o_init_done)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] addr;
    logic        fault;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem_m [DEPTH];
  bit          run_m = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_fetch(input logic [15:0] a);
    exp_t e;
    e.addr  = a;
    e.fault = (a >= DEPTH);
    e.inst  = (a < DEPTH) ? mem_m[a] : 16'hFFFF;
    return e;
  endfunction

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      chk("resp_valid", {31'd0, o_resp_valid}, {31'd0, q.size() != 0});
      if (o_resp_valid && q.size() != 0) begin
        chk("resp_inst",  {16'd0, o_resp_inst}, {16'd0, q[0].inst});
        chk("resp_addr",  {16'd0, o_resp_addr}, {16'd0, q[0].addr});
        chk("resp_fault", {31'd0, o_resp_fault}, {31'd0, q[0].fault});
      end
      if (q.size() != 0 && (i_flush || i_resp_ready)) void'(q.pop_front());
    end
  end

  // Entered at posedge+1; returns at the next posedge+1.
  task automatic step();
    bit rdy;
    bit acc;
    #1;
    rdy = 1'b0;
    acc = 1'b0;
    if (!i_reset) begin
      rdy = run_m && !i_load_en && (q.size() == 0 || i_resp_ready);
      chk("req_ready", {31'd0, o_req_ready}, {31'd0, rdy});
      acc = i_req_valid && rdy && !i_flush;
    end
    @(posedge i_clock);
    if (acc) q.push_back(model_fetch(i_req_addr));
    if (run_m && i_load_en && i_load_addr < DEPTH) mem_m[i_load_addr] = i_load_data;
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic rr, input logic fl,
                       input logic ld, input logic [15:0] la, input logic [15:0] ldat);
    i_req_valid  = v;
    i_req_addr   = a;
    i_resp_ready = rr;
    i_flush      = fl;
    i_load_en    = ld;
    i_load_addr  = la;
    i_load_data  = ldat;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  // Asserted mid-cycle so the output drop must not wait for a clock edge.
  task automatic assert_reset();
    i_reset = 1'b1;
    run_m   = 1'b0;
    q.delete();
    #1;
    chk("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst_init_done",  {31'd0, o_init_done},  32'd0);
    chk("rst_resp_inst",  {16'd0, o_resp_inst},  32'h0000FFFF);
    chk("rst_resp_addr",  {16'd0, o_resp_addr},  32'd0);
    chk("rst_resp_fault", {31'd0, o_resp_fault}, 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic wait_init();
    int cnt;
    cnt = 0;
    while (!o_init_done && cnt < 1000) begin
      step();
      cnt++;
    end
    chk("init_cycles", cnt, 32'd140);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'hFFFF;
    run_m = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge i_clock);
    #1;
    assert_reset();
    wait_init();

    // NOP fill visible at low, middle and last word
    drive(1'b1, 16'd0,   1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 16'd77,  1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 16'd139, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    idle(2);

    // load then back-to-back read
    drive(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd1, 16'h3201);
    drive(1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 16'd2, 16'h3401);
    drive(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    idle(2);

    // stall then release with a same-cycle accept
    drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd6, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 16'd6, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    idle(2);

    // flush with same-cycle request, then flush of a held response
    drive(1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    idle(1);
    drive(1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    idle(2);

    // out-of-range reads and an ignored out-of-range load
    drive(1'b1, 16'd140,   1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b1, 16'hFFFF,  1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1'b0, 16'd0,     1'b1, 1'b0, 1'b1, 16'd200, 16'h1234);
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 16'(a), 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra;
      logic [15:0] la;
      ra = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 149));
      la = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(140, 300)) : 16'($urandom_range(0, 139));
      drive(1'($urandom_range(0, 9) < 7), ra, 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 2), la, 16'($urandom));
    end
    idle(2);

    // reset with a pending response, then again part-way through INIT
    drive(1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    i_req_valid  = 1'b0;
    i_resp_ready = 1'b1;
    assert_reset();
    for (int i = 0; i < 60; i++) step();
    assert_reset();
    wait_init();
    drive(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
